axi_resp_delay: RTL and testbench

- Fixed-latency delay stage on the AXI read-data (R) and write-response (B) channels.
- Sits directly downstream of the FakeDRAM model's R/B outputs, in front of the memory-side AXI port of the core's interconnect.
- Models realistic DRAM access latency. The DPI memory model answers within one cycle, so every beat it produces is held here for LATENCY cycles.
- AR/AW/W are wired straight through at the harness top level and do not pass through this block.

---
 rtl/axi_resp_delay_pkg.sv | 28 ++
 rtl/axi_resp_delay_if.sv | 40 ++++
 rtl/resp_delay_queue.sv | 82 ++++++++
 rtl/axi_resp_delay.sv | 52 +++++
 tb/tb_axi_resp_delay.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_resp_delay_pkg.sv
// rtl/axi_resp_delay_pkg.sv - shared types, constants and parameter checks for axi_resp_delay
package axi_resp_delay_pkg;

  localparam int AGE_BITS      = 8;
  localparam int DEF_ID_BITS   = 5;
  localparam int DEF_DATA_BITS = 64;

  typedef struct packed {
    logic [DEF_ID_BITS-1:0]   id;
    logic [1:0]               resp;
    logic [DEF_DATA_BITS-1:0] data;
    logic                     last;
  } r_beat_t;

  typedef struct packed {
    logic [DEF_ID_BITS-1:0] id;
    logic [1:0]             resp;
  } b_resp_t;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_ok(input int latency, input int r_depth, input int b_depth);
    return (latency >= 1) && (latency <= 255) && is_pow2(r_depth) && is_pow2(b_depth);
  endfunction

endpackage

// File: rtl/axi_resp_delay_if.sv
// rtl/axi_resp_delay_if.sv - R/B input and output channel bundle of the response delay stage
interface axi_resp_delay_if #(
  parameter int ID_BITS   = 5,
  parameter int DATA_BITS = 64
);
  logic                 in_r_valid;
  logic                 in_r_ready;
  logic [ID_BITS-1:0]   in_r_bits_id;
  logic [1:0]           in_r_bits_resp;
  logic [DATA_BITS-1:0] in_r_bits_data;
  logic                 in_r_bits_last;
  logic                 out_r_valid;
  logic                 out_r_ready;
  logic [ID_BITS-1:0]   out_r_bits_id;
  logic [1:0]           out_r_bits_resp;
  logic [DATA_BITS-1:0] out_r_bits_data;
  logic                 out_r_bits_last;
  logic                 in_b_valid;
  logic                 in_b_ready;
  logic [ID_BITS-1:0]   in_b_bits_id;
  logic [1:0]           in_b_bits_resp;
  logic                 out_b_valid;
  logic                 out_b_ready;
  logic [ID_BITS-1:0]   out_b_bits_id;
  logic [1:0]           out_b_bits_resp;

  modport slave (
    input  in_r_valid, in_r_bits_id, in_r_bits_resp, in_r_bits_data, in_r_bits_last, out_r_ready,
    input  in_b_valid, in_b_bits_id, in_b_bits_resp, out_b_ready,
    output in_r_ready, out_r_valid, out_r_bits_id, out_r_bits_resp, out_r_bits_data, out_r_bits_last,
    output in_b_ready, out_b_valid, out_b_bits_id, out_b_bits_resp
  );

  modport master (
    output in_r_valid, in_r_bits_id, in_r_bits_resp, in_r_bits_data, in_r_bits_last, out_r_ready,
    output in_b_valid, in_b_bits_id, in_b_bits_resp, out_b_ready,
    input  in_r_ready, out_r_valid, out_r_bits_id, out_r_bits_resp, out_r_bits_data, out_r_bits_last,
    input  in_b_ready, out_b_valid, out_b_bits_id, out_b_bits_resp
  );
endinterface

// File: rtl/resp_delay_queue.sv
// rtl/resp_delay_queue.sv - circular FIFO whose head is released only once it has aged LATENCY cycles
module resp_delay_queue
  import axi_resp_delay_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int LATENCY = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AGE_BITS-1:0] LAT_AGE = AGE_BITS'(LATENCY);

  logic [IW:0]           head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]      occ_q, occ_d;
  logic [AGE_BITS-1:0]   age_q [DEPTH];
  logic [AGE_BITS-1:0]   age_d [DEPTH];
  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [IW-1:0]         head_idx, tail_idx;
  logic                  full, empty, push, pop;

  always_comb begin
    head_idx  = head_q[IW-1:0];
    tail_idx  = tail_q[IW-1:0];
    empty     = (head_q == tail_q);
    full      = (head_idx == tail_idx) && (head_q[IW] != tail_q[IW]);
    // No pop bypass: a full queue refuses input even when its head leaves this cycle.
    in_ready  = !reset && !full;
    out_valid = !reset && !empty && (age_q[head_idx] == LAT_AGE);
    out_data  = out_valid ? mem_q[head_idx] : '0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    head_d    = head_q + (IW + 1)'(pop);
    tail_d    = tail_q + (IW + 1)'(push);
    occ_d     = occ_q;
    age_d     = age_q;
    mem_d     = mem_q;
    // Ages saturate at LATENCY so an arbitrarily long stall never re-hides the head.
    for (int i = 0; i < DEPTH; i++) begin
      if (occ_q[i] && (age_q[i] < LAT_AGE)) begin
        age_d[i] = age_q[i] + 8'd1;
      end
    end
    if (pop) begin
      occ_d[head_idx] = 1'b0;
    end
    if (push) begin
      occ_d[tail_idx] = 1'b1;
      age_d[tail_idx] = 8'd1;
      mem_d[tail_idx] = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      age_q  <= age_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/axi_resp_delay.sv
// rtl/axi_resp_delay.sv - fixed-latency delay of the AXI R and B channels using two independent queues
module axi_resp_delay
  import axi_resp_delay_pkg::*;
#(
  parameter int ID_BITS   = 5,
  parameter int DATA_BITS = 64,
  parameter int LATENCY   = 40,
  parameter int R_DEPTH   = 16,
  parameter int B_DEPTH   = 8
) (
  input  logic              clock,
  input  logic              reset,
  axi_resp_delay_if.slave   bus
);
  localparam int R_W = ID_BITS + 2 + DATA_BITS + 1;
  localparam int B_W = ID_BITS + 2;

  if (!params_ok(LATENCY, R_DEPTH, B_DEPTH)) begin : g_bad_params
    $error("axi_resp_delay: LATENCY must be 1..255 and depths powers of two >= 2");
  end

  logic [R_W-1:0] r_in, r_out;
  logic [B_W-1:0] b_in, b_out;

  assign r_in = {bus.in_r_bits_id, bus.in_r_bits_resp, bus.in_r_bits_data, bus.in_r_bits_last};
  assign {bus.out_r_bits_id, bus.out_r_bits_resp, bus.out_r_bits_data, bus.out_r_bits_last} = r_out;
  assign b_in = {bus.in_b_bits_id, bus.in_b_bits_resp};
  assign {bus.out_b_bits_id, bus.out_b_bits_resp} = b_out;

  resp_delay_queue #(.WIDTH(R_W), .DEPTH(R_DEPTH), .LATENCY(LATENCY)) u_r_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.in_r_valid),
    .in_ready  (bus.in_r_ready),
    .in_data   (r_in),
    .out_valid (bus.out_r_valid),
    .out_ready (bus.out_r_ready),
    .out_data  (r_out)
  );

  resp_delay_queue #(.WIDTH(B_W), .DEPTH(B_DEPTH), .LATENCY(LATENCY)) u_b_queue (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (bus.in_b_valid),
    .in_ready  (bus.in_b_ready),
    .in_data   (b_in),
    .out_valid (bus.out_b_valid),
    .out_ready (bus.out_b_ready),
    .out_data  (b_out)
  );

endmodule

// File: tb/tb_axi_resp_delay.sv
// tb/tb_axi_resp_delay.sv - self-checking bench for axi_resp_delay with a timestamp reference model
module tb_axi_resp_delay;
  import axi_resp_delay_pkg::*;

  localparam int LAT1 = 40;
  localparam int LAT2 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axi_resp_delay_if #(.ID_BITS(5), .DATA_BITS(64)) b1 ();
  axi_resp_delay_if #(.ID_BITS(5), .DATA_BITS(64)) b2 ();

  axi_resp_delay #(.ID_BITS(5), .DATA_BITS(64), .LATENCY(LAT1), .R_DEPTH(16), .B_DEPTH(8)) dut1 (
    .clock(clk), .reset(rst), .bus(b1));
  axi_resp_delay #(.ID_BITS(5), .DATA_BITS(64), .LATENCY(LAT2), .R_DEPTH(4), .B_DEPTH(2)) dut2 (
    .clock(clk), .reset(rst), .bus(b2));

  // Channels: 0 = dut1 R, 1 = dut1 B, 2 = dut2 R, 3 = dut2 B
  logic        in_v [4], in_rdy [4], out_v [4], out_rdy [4];
  logic [71:0] in_p [4], out_p [4];
  int          depth_c [4] = '{16, 8, 4, 2};
  int          lat_c [4]   = '{LAT1, LAT1, LAT2, LAT2};

  always_comb begin
    in_v[0] = b1.in_r_valid;  in_rdy[0] = b1.in_r_ready;  out_v[0] = b1.out_r_valid;  out_rdy[0] = b1.out_r_ready;
    in_v[1] = b1.in_b_valid;  in_rdy[1] = b1.in_b_ready;  out_v[1] = b1.out_b_valid;  out_rdy[1] = b1.out_b_ready;
    in_v[2] = b2.in_r_valid;  in_rdy[2] = b2.in_r_ready;  out_v[2] = b2.out_r_valid;  out_rdy[2] = b2.out_r_ready;
    in_v[3] = b2.in_b_valid;  in_rdy[3] = b2.in_b_ready;  out_v[3] = b2.out_b_valid;  out_rdy[3] = b2.out_b_ready;
    in_p[0]  = {b1.in_r_bits_id, b1.in_r_bits_resp, b1.in_r_bits_data, b1.in_r_bits_last};
    out_p[0] = {b1.out_r_bits_id, b1.out_r_bits_resp, b1.out_r_bits_data, b1.out_r_bits_last};
    in_p[1]  = {65'd0, b1.in_b_bits_id, b1.in_b_bits_resp};
    out_p[1] = {65'd0, b1.out_b_bits_id, b1.out_b_bits_resp};
    in_p[2]  = {b2.in_r_bits_id, b2.in_r_bits_resp, b2.in_r_bits_data, b2.in_r_bits_last};
    out_p[2] = {b2.out_r_bits_id, b2.out_r_bits_resp, b2.out_r_bits_data, b2.out_r_bits_last};
    in_p[3]  = {65'd0, b2.in_b_bits_id, b2.in_b_bits_resp};
    out_p[3] = {65'd0, b2.out_b_bits_id, b2.out_b_bits_resp};
  end

  int n_cmp = 0;
  int n_bad = 0;
  int n_pop [4] = '{0, 0, 0, 0};
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int ch, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s ch%0d cyc%0d: got %h, expected %h", name, ch, cyc, act, exp);
    end
  endtask

  function automatic logic [71:0] pack(input int ch, input logic [4:0] id, input logic [1:0] resp,
                                       input logic [63:0] data, input logic last);
    r_beat_t rb;
    b_resp_t bb;
    if (ch % 2 == 0) begin
      rb = '{id: id, resp: resp, data: data, last: last};
      return rb;
    end
    bb = '{id: id, resp: resp};
    return {65'd0, bb};
  endfunction

  task automatic set_in(input int ch, input logic v, input logic [71:0] p);
    case (ch)
      0: begin b1.in_r_valid = v; {b1.in_r_bits_id, b1.in_r_bits_resp, b1.in_r_bits_data, b1.in_r_bits_last} = p; end
      1: begin b1.in_b_valid = v; {b1.in_b_bits_id, b1.in_b_bits_resp} = p[6:0]; end
      2: begin b2.in_r_valid = v; {b2.in_r_bits_id, b2.in_r_bits_resp, b2.in_r_bits_data, b2.in_r_bits_last} = p; end
      default: begin b2.in_b_valid = v; {b2.in_b_bits_id, b2.in_b_bits_resp} = p[6:0]; end
    endcase
  endtask

  task automatic set_rdy(input int ch, input logic r);
    case (ch)
      0: b1.out_r_ready = r;
      1: b1.out_b_ready = r;
      2: b2.out_r_ready = r;
      default: b2.out_b_ready = r;
    endcase
  endtask

  // Reference model: each accepted beat carries its acceptance cycle; the head is visible LATENCY cycles later.
  logic [71:0] mq [4][$];
  int          tq [4][$];

  always @(negedge clk) begin
    logic er, ev;
    logic [71:0] ep;
    if (chk_en) begin
      for (int c = 0; c < 4; c++) begin
        er = !rst && (mq[c].size() < depth_c[c]);
        ev = 1'b0;
        if (!rst && mq[c].size() > 0) ev = (cyc >= tq[c][0] + lat_c[c]);
        ep = ev ? mq[c][0] : 72'd0;
        chk("in_ready", c, 72'(in_rdy[c]), 72'(er));
        chk("out_valid", c, 72'(out_v[c]), 72'(ev));
        chk("out_bits", c, out_p[c], ep);
        if (rst) begin
          mq[c].delete();
          tq[c].delete();
        end else begin
          if (ev && out_rdy[c]) begin
            void'(mq[c].pop_front());
            void'(tq[c].pop_front());
            n_pop[c]++;
          end
          if (in_v[c] && er) begin
            mq[c].push_back(in_p[c]);
            tq[c].push_back(cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int ch, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (out_v[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    int          ch;
    logic [4:0]  id;
    logic [1:0]  resp;
    logic [63:0] data;
    logic        last;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc, acc_n, p0, unstable;
    logic [71:0] snap;
    int got_ids [$];

    vecs[0] = '{0, 5'd3,  2'd0, 64'hDEAD_BEEF,            1'b1, 40};
    vecs[1] = '{0, 5'd31, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF,  1'b0, 40};
    vecs[2] = '{1, 5'd2,  2'd2, 64'h0,                    1'b0, 40};
    vecs[3] = '{2, 5'd7,  2'd1, 64'h0123_4567_89AB_CDEF,  1'b1, 1};
    vecs[4] = '{3, 5'd30, 2'd3, 64'h0,                    1'b0, 1};
    vecs[5] = '{0, 5'd0,  2'd0, 64'h0,                    1'b0, 40};

    for (int c = 0; c < 4; c++) begin
      set_in(c, 1'b0, 72'd0);
      set_rdy(c, 1'b1);
    end
    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single beats, one table row at a time
    foreach (vecs[k]) begin
      tick();
      acc = cyc;
      set_in(vecs[k].ch, 1'b1, pack(vecs[k].ch, vecs[k].id, vecs[k].resp, vecs[k].data, vecs[k].last));
      tick();
      set_in(vecs[k].ch, 1'b0, 72'd0);
      wait_out(vecs[k].ch, 100, ok);
      chk("vec_seen", k, 72'(ok), 72'd1);
      chk("vec_latency", k, 72'(cyc - acc), 72'(vecs[k].exp_lat));
      chk("vec_bits", k, out_p[vecs[k].ch],
          pack(vecs[k].ch, vecs[k].id, vecs[k].resp, vecs[k].data, vecs[k].last));
      tick();
    end

    // 8-beat burst through dut1 R: consecutive output cycles, last only on beat 8
    tick();
    acc = cyc;
    for (int i = 0; i < 8; i++) begin
      set_in(0, 1'b1, pack(0, 5'd5, 2'd0, 64'h100 + 64'(i), i == 7));
      tick();
    end
    set_in(0, 1'b0, 72'd0);
    wait_out(0, 100, ok);
    chk("burst_first_latency", 0, 72'(cyc - acc), 72'(LAT1));
    for (int i = 0; i < 8; i++) begin
      chk("burst_valid", i, 72'(out_v[0]), 72'd1);
      chk("burst_bits", i, out_p[0], pack(0, 5'd5, 2'd0, 64'h100 + 64'(i), i == 7));
      @(negedge clk);
    end
    chk("burst_after_valid", 0, 72'(out_v[0]), 72'd0);
    tick();

    // Depth-4 queue stalled, 6 beats offered: 4 accepted, then drain in order
    set_rdy(2, 1'b0);
    acc_n = 0;
    for (int k = 0; k < 12; k++) begin
      set_in(2, acc_n < 6, pack(2, 5'(acc_n + 1), 2'd0, 64'(acc_n), 1'b0));
      @(negedge clk);
      if (in_v[2] && in_rdy[2]) acc_n++;
      tick();
    end
    chk("depth_accepts", 2, 72'(acc_n), 72'd4);
    @(negedge clk);
    chk("depth_full_ready", 2, 72'(in_rdy[2]), 72'd0);
    tick();
    set_rdy(2, 1'b1);
    for (int k = 0; k < 30; k++) begin
      set_in(2, acc_n < 6, pack(2, 5'(acc_n + 1), 2'd0, 64'(acc_n), 1'b0));
      @(negedge clk);
      if (in_v[2] && in_rdy[2]) acc_n++;
      if (out_v[2]) got_ids.push_back(int'(out_p[2][71:67]));
      tick();
    end
    set_in(2, 1'b0, 72'd0);
    chk("depth_drain_count", 2, 72'(got_ids.size()), 72'd6);
    for (int i = 0; i < 6 && i < got_ids.size(); i++) chk("depth_drain_order", i, 72'(got_ids[i]), 72'(i + 1));

    // B stalled 1000 cycles with two responses queued
    set_rdy(1, 1'b0);
    set_in(1, 1'b1, pack(1, 5'd9, 2'd1, 64'd0, 1'b0));
    tick();
    set_in(1, 1'b1, pack(1, 5'd10, 2'd2, 64'd0, 1'b0));
    tick();
    set_in(1, 1'b0, 72'd0);
    wait_out(1, 100, ok);
    chk("bstall_seen", 1, 72'(ok), 72'd1);
    snap = out_p[1];
    chk("bstall_head", 1, snap, pack(1, 5'd9, 2'd1, 64'd0, 1'b0));
    unstable = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!out_v[1] || out_p[1] !== snap) unstable++;
    end
    chk("bstall_stable", 1, 72'(unstable), 72'd0);
    tick();
    set_rdy(1, 1'b1);
    @(negedge clk);
    chk("brel_first", 1, {71'd0, out_v[1]} | out_p[1], pack(1, 5'd9, 2'd1, 64'd0, 1'b0) | 72'd1);
    @(negedge clk);
    chk("brel_second", 1, {71'd0, out_v[1]} | out_p[1], pack(1, 5'd10, 2'd2, 64'd0, 1'b0) | 72'd1);
    @(negedge clk);
    chk("brel_empty", 1, 72'(out_v[1]), 72'd0);
    tick();

    // Simultaneous R and B into dut1
    tick();
    acc = cyc;
    set_in(0, 1'b1, pack(0, 5'd1, 2'd0, 64'h55, 1'b1));
    set_in(1, 1'b1, pack(1, 5'd2, 2'd0, 64'd0, 1'b0));
    tick();
    set_in(0, 1'b0, 72'd0);
    set_in(1, 1'b0, 72'd0);
    wait_out(0, 100, ok);
    chk("simul_r_latency", 0, 72'(cyc - acc), 72'(LAT1));
    chk("simul_b_valid", 1, 72'(out_v[1]), 72'd1);
    chk("simul_b_bits", 1, out_p[1], pack(1, 5'd2, 2'd0, 64'd0, 1'b0));
    tick();

    // Reset with 3 R beats queued: they are discarded; only the later beat emerges
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1'b1, pack(0, 5'd20 + 5'(i), 2'd0, 64'(i), 1'b0));
      tick();
    end
    set_in(0, 1'b0, 72'd0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0 = n_pop[0];
    repeat (4) tick();
    acc = cyc;
    set_in(0, 1'b1, pack(0, 5'd17, 2'd1, 64'hCAFE, 1'b1));
    tick();
    set_in(0, 1'b0, 72'd0);
    wait_out(0, 100, ok);
    chk("rst_new_latency", 0, 72'(cyc - acc), 72'(LAT1));
    chk("rst_new_bits", 0, out_p[0], pack(0, 5'd17, 2'd1, 64'hCAFE, 1'b1));
    repeat (60) tick();
    chk("rst_only_one", 0, 72'(n_pop[0] - p0), 72'd1);

    // Random traffic on all four channels, with rare resets
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 4; c++) begin
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        set_in(c, $urandom_range(0, 99) < 60, (c % 2 == 0) ? r[71:0] : {65'd0, r[6:0]});
        set_rdy(c, $urandom_range(0, 99) < 70);
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_in(c, 1'b0, 72'd0);
      set_rdy(c, 1'b1);
    end
    repeat (100) tick();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
